// File: rtl/qsys_design_servo_pwm.sv
// RC-servo pulse generator fed by the PIO position byte: one pulse per frame,
// slew-limited position and width updates applied only at frame boundaries.
module qsys_design_servo_pwm #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] position,
  input  logic       enable,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_pos
);

  localparam int unsigned DIV       = CLK_HZ / 1000000;
  localparam int unsigned PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned UW        = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned RANGE     = MAX_US - MIN_US;
  localparam logic [7:0]  POS_RST   = 8'd128;
  localparam logic [15:0] WIDTH_RST = 16'(MIN_US + ((128 * RANGE) >> 8));
  localparam logic [8:0]  STEP9     = 9'(SLEW_STEP);

  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;
  logic          fs_q, fs_d;
  logic          en_q, en_d;
  logic [7:0]    cur_q, cur_d;
  logic [15:0]   width_q, width_d;
  logic          pwm_q, pwm_d;

  logic              us_tick;
  logic              frame_ev;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [7:0]        nxt_pos;
  logic [31:0]       prod;
  logic [15:0]       nxt_width;

  assign us_tick  = (pre_q == PW'(DIV - 1));
  assign frame_ev = us_tick && (us_q == UW'(PERIOD_US - 1));

  // Microsecond prescaler and frame-position counter.
  always_comb begin
    pre_d = us_tick ? '0 : pre_q + PW'(1);
    us_d  = us_q;
    if (us_tick) begin
      us_d = (us_q == UW'(PERIOD_US - 1)) ? '0 : us_q + UW'(1);
    end
  end

  // Slew toward the target; the 9-bit signed difference keeps the step from wrapping.
  always_comb begin
    diff = $signed({1'b0, position}) - $signed({1'b0, cur_q});
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    if ((SLEW_STEP == 0) || (mag <= STEP9)) begin
      nxt_pos = position;
    end else if (diff[8]) begin
      nxt_pos = cur_q - 8'(SLEW_STEP);
    end else begin
      nxt_pos = cur_q + 8'(SLEW_STEP);
    end
    prod      = 32'(nxt_pos) * 32'(RANGE);
    nxt_width = 16'(32'(MIN_US) + (prod >> 8));
  end

  // Frame-boundary latching; the pulse is high while the frame's microsecond count is below width.
  always_comb begin
    fs_d    = frame_ev;
    en_d    = frame_ev ? enable    : en_q;
    cur_d   = frame_ev ? nxt_pos   : cur_q;
    width_d = frame_ev ? nxt_width : width_q;
    pwm_d   = en_d && (32'(us_d) < 32'(width_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      us_q    <= '0;
      fs_q    <= 1'b0;
      en_q    <= 1'b0;
      cur_q   <= POS_RST;
      width_q <= WIDTH_RST;
      pwm_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      us_q    <= us_d;
      fs_q    <= fs_d;
      en_q    <= en_d;
      cur_q   <= cur_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
  assign cur_pos     = cur_q;

endmodule

// File: tb/tb_qsys_design_servo_pwm.sv
// Directed scoreboard bench: two instances (slew 4 and unlimited) share stimulus;
// per-frame expected position and pulse length are queued, then popped and compared.
module tb_qsys_design_servo_pwm;

  localparam int unsigned CLK_HZ = 4000000;
  localparam int unsigned DIV    = 4;
  localparam int unsigned PER    = 100;
  localparam int unsigned MINU   = 10;
  localparam int unsigned MAXU   = 20;
  localparam int FRAME = PER * DIV;

  logic       clk;
  logic       reset;
  logic [7:0] position;
  logic       enable;
  logic       pwm4, fs4, pwm0, fs0;
  logic [7:0] cur4, cur0;

  typedef struct {
    logic [7:0] c4;
    logic [7:0] c0;
    int         h4;
    int         h0;
  } exp_t;

  exp_t       sb_q[$];
  int         checks;
  int         errors;
  logic [7:0] m4, m0;

  qsys_design_servo_pwm #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PER), .MIN_US(MINU), .MAX_US(MAXU), .SLEW_STEP(4)
  ) u_dut4 (
    .clk(clk), .reset(reset), .position(position), .enable(enable),
    .pwm_out(pwm4), .frame_start(fs4), .cur_pos(cur4)
  );

  qsys_design_servo_pwm #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PER), .MIN_US(MINU), .MAX_US(MAXU), .SLEW_STEP(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .position(position), .enable(enable),
    .pwm_out(pwm0), .frame_start(fs0), .cur_pos(cur0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt, input int step);
    int d;
    d = int'(tgt) - int'(cur);
    if (step == 0 || (d <= step && d >= -step)) return tgt;
    return (d > 0) ? 8'(int'(cur) + step) : 8'(int'(cur) - step);
  endfunction

  function automatic int hi_cycles(input logic [7:0] c, input logic en);
    if (!en) return 0;
    return (int'(MINU) + ((int'(c) * int'(MAXU - MINU)) >> 8)) * int'(DIV);
  endfunction

  // Model the next frame event using the stimulus currently applied.
  task automatic expect_next();
    exp_t e;
    m4 = slew(m4, position, 4);
    m0 = slew(m0, position, 0);
    e.c4 = m4;
    e.c0 = m0;
    e.h4 = hi_cycles(m4, enable);
    e.h0 = hi_cycles(m0, enable);
    sb_q.push_back(e);
  endtask

  task automatic wait_first_frame(input string tag);
    int n;
    logic saw_hi;
    n = 0;
    saw_hi = 1'b0;
    while (n < FRAME + 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (fs4 === 1'b1) break;
      if (pwm4 !== 1'b0 || pwm0 !== 1'b0) saw_hi = 1'b1;
    end
    chk({tag, " first frame cycle"}, 32'(n), 32'(FRAME));
    chk({tag, " no pulse before first frame"}, 32'(saw_hi), 32'd0);
    chk({tag, " frame_start slew0"}, 32'(fs0), 32'd1);
  endtask

  // Measure one frame; optionally change inputs at cycle chg_at within it.
  task automatic measure_frame(input string tag, input int chg_at,
                               input logic [7:0] npos, input logic nen);
    int waited, h4, h0;
    logic [7:0] c4, c0;
    exp_t e;
    waited = 0;
    while (fs4 !== 1'b1 && waited < FRAME + 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " frame_start"}, 32'(fs4), 32'd1);
    chk({tag, " frame_start slew0"}, 32'(fs0), 32'd1);
    c4 = cur4;
    c0 = cur0;
    h4 = 0;
    h0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) begin
        position = npos;
        enable   = nen;
      end
      h4 += int'(pwm4);
      h0 += int'(pwm0);
    end
    chk({tag, " scoreboard entry"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk({tag, " cur_pos slew4"}, 32'(c4), 32'(e.c4));
    chk({tag, " cur_pos slew0"}, 32'(c0), 32'(e.c0));
    chk({tag, " high cycles slew4"}, 32'(h4), 32'(e.h4));
    chk({tag, " high cycles slew0"}, 32'(h0), 32'(e.h0));
  endtask

  initial begin
    int w;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    position = 8'd128;
    enable   = 1'b1;
    m4       = 8'd128;
    m0       = 8'd128;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", 32'(pwm4), 32'd0);
    chk("reset frame_start", 32'(fs4), 32'd0);
    chk("reset cur_pos slew4", 32'(cur4), 32'd128);
    chk("reset cur_pos slew0", 32'(cur0), 32'd128);
    reset = 1'b0;

    expect_next();
    wait_first_frame("por");
    measure_frame("f1 midpulse change", 20, 8'd255, 1'b1);
    expect_next();
    measure_frame("f2 to 255", -1, 8'd0, 1'b0);
    position = 8'd0;
    expect_next();
    measure_frame("f3 to 0", -1, 8'd0, 1'b0);

    position = 8'd200;
    repeat (19) begin
      expect_next();
      measure_frame("ramp 200", -1, 8'd0, 1'b0);
    end
    chk("hold at 200", 32'(cur4), 32'd200);

    position = 8'd130;
    repeat (18) begin
      expect_next();
      measure_frame("ramp 130", -1, 8'd0, 1'b0);
    end
    position = 8'd2;
    repeat (32) begin
      expect_next();
      measure_frame("ramp 2", -1, 8'd0, 1'b0);
    end
    chk("reached 2", 32'(cur4), 32'd2);
    position = 8'd0;
    expect_next();
    measure_frame("2 to 0", -1, 8'd0, 1'b0);
    chk("no wrap at 0", 32'(cur4), 32'd0);

    enable   = 1'b0;
    position = 8'd100;
    expect_next();
    measure_frame("enable off", -1, 8'd0, 1'b0);
    enable = 1'b1;
    expect_next();
    measure_frame("enable drop midpulse", 20, 8'd100, 1'b0);
    expect_next();
    measure_frame("after drop", -1, 8'd0, 1'b0);
    enable = 1'b1;
    expect_next();
    measure_frame("re-enable", -1, 8'd0, 1'b0);

    w = 0;
    while (fs4 !== 1'b1 && w < FRAME + 50) begin
      @(negedge clk);
      w++;
    end
    repeat (30) @(negedge clk);
    chk("pulse high before reset", 32'(pwm4), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset pwm slew4", 32'(pwm4), 32'd0);
    chk("async reset pwm slew0", 32'(pwm0), 32'd0);
    chk("async reset cur_pos slew4", 32'(cur4), 32'd128);
    chk("async reset cur_pos slew0", 32'(cur0), 32'd128);
    chk("async reset frame_start", 32'(fs4), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    position = 8'd130;
    m4       = 8'd128;
    m0       = 8'd128;
    expect_next();
    wait_first_frame("post reset");
    measure_frame("128 to 130", -1, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
